// File: rtl/cpu_debug_slave_sysclk_cmdq.sv
// -----------------------------------------------------------------------------
// cpu_debug_slave_sysclk_cmdq
//
// System-clock side of the CPU JTAG debug slave. The TCK domain reports its
// Update-IR and Exit1-DR events by flipping a toggle line. This block
// synchronises both toggles, keeps the last virtual IR, and queues one
// {IR, shift-register} command per Exit1-DR in a small show-ahead FIFO. The
// OCI/break logic drains the FIFO with a valid/ready handshake. Each pop
// produces a registered one-hot take_action / take_no_action strobe.
//
// Optional feature macro: CPU_DEBUG_CMDQ_STATS_EN
//   When this macro is defined, the block adds a saturating 8-bit drop_count
//   output that counts dropped pushes.
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   vs_uir_tgl      toggles once per TCK-domain Update-IR
//   vs_e1dr_tgl     toggles once per TCK-domain Exit1-DR
//   ir_in           virtual IR (stable across an uir toggle)
//   sr              shift register (stable across an e1dr toggle)
//   cmd_ready       consumer accepts the head entry
//   clr_ovf         clears the overflow flag (and drop_count)
//   cmd_valid       FIFO non-empty
//   cmd_ir          IR of the head entry
//   cmd_data        data of the head entry
//   take_action     one-cycle one-hot strobe, head data MSB = 1
//   take_no_action  one-cycle one-hot strobe, head data MSB = 0
//   ir_latched      last IR captured on Update-IR
//   fifo_count      FIFO occupancy
//   overflow        sticky, set when a push is dropped
//   drop_count      (stats build only) saturating count of dropped pushes
// -----------------------------------------------------------------------------
module cpu_debug_slave_sysclk_cmdq #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vs_uir_tgl,
    input  logic                       vs_e1dr_tgl,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [DATA_W-1:0]          sr,
    input  logic                       cmd_ready,
    input  logic                       clr_ovf,
    output logic                       cmd_valid,
    output logic [IR_W-1:0]            cmd_ir,
    output logic [DATA_W-1:0]          cmd_data,
    output logic [(2**IR_W)-1:0]       take_action,
    output logic [(2**IR_W)-1:0]       take_no_action,
    output logic [IR_W-1:0]            ir_latched,
    output logic [$clog2(DEPTH):0]     fifo_count,
`ifdef CPU_DEBUG_CMDQ_STATS_EN
    output logic [7:0]                 drop_count,
`endif
    output logic                       overflow
);

    localparam int NCMD    = 2**IR_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = IR_W + DATA_W;

    // ------------------------------------------------------------------
    // Toggle synchronisers. Channel 0 carries Update-IR and channel 1
    // carries Exit1-DR.
    // ------------------------------------------------------------------
    logic [1:0] tgl_in;
    logic [1:0] edge_raw;
    logic       primed_q;
    logic [1:0] evt;

    assign tgl_in = {vs_e1dr_tgl, vs_uir_tgl};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   hist_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= '0;
                    hist_q <= 1'b0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_in[gi]};
                    hist_q <= sync_q[SYNC_STAGES-1];
                end
            end

            assign edge_raw[gi] = sync_q[SYNC_STAGES-1] ^ hist_q;
            assign evt[gi]      = primed_q & edge_raw[gi];
        end
    endgenerate

    // A 1 shifts through a chain that mirrors the data path. When the 1
    // reaches the history position, the history flop holds a real sample of
    // the input. Only after that does last^history mean an edge, so a toggle
    // line that rests at 1 out of reset cannot fake an event.
    logic [SYNC_STAGES:0] fill_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            fill_q   <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            primed_q <= fill_q[SYNC_STAGES];
        end
    end

    logic uir_evt;
    logic e1dr_evt;

    assign uir_evt  = evt[0];
    assign e1dr_evt = evt[1];

    // ------------------------------------------------------------------
    // Virtual IR latch. An Update-IR in the same cycle as an Exit1-DR
    // forwards ir_in straight into the pushed entry.
    // ------------------------------------------------------------------
    logic [IR_W-1:0] ir_latched_q;
    logic [IR_W-1:0] ir_latched_d;
    logic [IR_W-1:0] push_ir;

    always_comb begin
        ir_latched_d = ir_latched_q;
        if (uir_evt) begin
            ir_latched_d = ir_in;
        end
    end

    assign push_ir = uir_evt ? ir_in : ir_latched_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_latched_q <= '0;
        end else begin
            ir_latched_q <= ir_latched_d;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO. The head entry is read combinationally from
    // storage, so consumers see it in the same cycle that cmd_valid rises.
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               pop;
    logic               push_ok;
    logic               drop;

    assign head      = mem_q[rd_ptr_q];
    assign cmd_valid = (count_q != '0);
    assign cmd_ir    = head[ENTRY_W-1 -: IR_W];
    assign cmd_data  = head[DATA_W-1:0];
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop       = cmd_valid & cmd_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot this
    // push needs.
    assign push_ok   = e1dr_evt & (~full | pop);
    assign drop      = e1dr_evt & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_ir, sr};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign fifo_count = count_q;

    // ------------------------------------------------------------------
    // Overflow flag. A drop in the clearing cycle wins over clr_ovf.
    // ------------------------------------------------------------------
    logic overflow_q;
    logic overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef CPU_DEBUG_CMDQ_STATS_EN
    // Saturating drop counter. A drop in the clearing cycle restarts the
    // count at 1.
    logic [7:0] drop_cnt_q;
    logic [7:0] drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            if (clr_ovf) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (clr_ovf) begin
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Action strobes. These are registered from the popped head entry, so
    // they appear one cycle after the pop and last exactly one cycle.
    // ------------------------------------------------------------------
    logic [NCMD-1:0] take_action_q;
    logic [NCMD-1:0] take_action_d;
    logic [NCMD-1:0] take_no_action_q;
    logic [NCMD-1:0] take_no_action_d;

    always_comb begin
        take_action_d    = '0;
        take_no_action_d = '0;
        if (pop) begin
            if (cmd_data[DATA_W-1]) begin
                take_action_d[cmd_ir] = 1'b1;
            end else begin
                take_no_action_d[cmd_ir] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            take_action_q    <= '0;
            take_no_action_q <= '0;
        end else begin
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
        end
    end

    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign ir_latched     = ir_latched_q;

endmodule

// File: tb/tb_cpu_debug_slave_sysclk_cmdq.sv
module tb_cpu_debug_slave_sysclk_cmdq;

    localparam int DATA_W  = 38;
    localparam int IR_W    = 2;
    localparam int DEPTH   = 4;
    localparam int S       = 2;
    localparam int NCMD    = 4;
    localparam int ENTRY_W = IR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              vs_uir_tgl;
    logic              vs_e1dr_tgl;
    logic [IR_W-1:0]   ir_in;
    logic [DATA_W-1:0] sr;
    logic              cmd_ready;
    logic              clr_ovf;
    logic              cmd_valid;
    logic [IR_W-1:0]   cmd_ir;
    logic [DATA_W-1:0] cmd_data;
    logic [NCMD-1:0]   take_action;
    logic [NCMD-1:0]   take_no_action;
    logic [IR_W-1:0]   ir_latched;
    logic [2:0]        fifo_count;
    logic              overflow;
`ifdef CPU_DEBUG_CMDQ_STATS_EN
    logic [7:0]        drop_count;
`endif

    always #5 clk = ~clk;

    cpu_debug_slave_sysclk_cmdq #(
        .DATA_W(DATA_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(S)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .vs_uir_tgl(vs_uir_tgl),
        .vs_e1dr_tgl(vs_e1dr_tgl),
        .ir_in(ir_in),
        .sr(sr),
        .cmd_ready(cmd_ready),
        .clr_ovf(clr_ovf),
        .cmd_valid(cmd_valid),
        .cmd_ir(cmd_ir),
        .cmd_data(cmd_data),
        .take_action(take_action),
        .take_no_action(take_no_action),
        .ir_latched(ir_latched),
        .fifo_count(fifo_count),
`ifdef CPU_DEBUG_CMDQ_STATS_EN
        .drop_count(drop_count),
`endif
        .overflow(overflow)
    );

    int checks   = 0;
    int failures = 0;

    logic [ENTRY_W-1:0] exp_q[$];
    logic [IR_W-1:0]    ir_cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle_uir(input logic [IR_W-1:0] ir);
        ir_in      = ir;
        vs_uir_tgl = ~vs_uir_tgl;
        $display("uir  ir=%0d", ir);
    endtask

    task automatic toggle_e1dr(input logic [DATA_W-1:0] d, input bit expect_push);
        sr          = d;
        vs_e1dr_tgl = ~vs_e1dr_tgl;
        if (expect_push) exp_q.push_back({ir_cur, d});
        $display("e1dr ir=%0d data=%010h queued=%0d", ir_cur, d, expect_push);
    endtask

    // Scoreboard monitor. At each falling edge it first checks the strobes
    // that the previous pop should have produced. It then checks the head
    // entry against the queue whenever a pop is about to happen.
    initial begin : monitor
        logic              pend;
        logic [NCMD-1:0]   exp_ta;
        logic [NCMD-1:0]   exp_tna;
        logic [NCMD-1:0]   one;
        logic [ENTRY_W-1:0] e;
        pend    = 1'b0;
        exp_ta  = '0;
        exp_tna = '0;
        one     = 1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                chk("take_action", 64'(take_action), pend ? 64'(exp_ta) : 64'd0);
                chk("take_no_action", 64'(take_no_action), pend ? 64'(exp_tna) : 64'd0);
                pend = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_unexpected", 64'(cmd_data), 64'h0);
                        failures += (cmd_data == 0) ? 1 : 0;
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd_ir", 64'(cmd_ir), 64'(e[ENTRY_W-1 -: IR_W]));
                        chk("cmd_data", 64'(cmd_data), 64'(e[DATA_W-1:0]));
                        exp_ta  = e[DATA_W-1] ? (one << e[ENTRY_W-1 -: IR_W]) : '0;
                        exp_tna = e[DATA_W-1] ? '0 : (one << e[ENTRY_W-1 -: IR_W]);
                        pend    = 1'b1;
                        $display("pop  ir=%0d data=%010h", cmd_ir, cmd_data);
                    end
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        vs_uir_tgl  = 1'b0;
        vs_e1dr_tgl = 1'b1;
        ir_in       = '0;
        sr          = '0;
        cmd_ready   = 1'b0;
        clr_ovf     = 1'b0;
        ir_cur      = '0;

        // Reset state, with the e1dr toggle resting at 1.
        tick(3);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_ta", 64'(take_action), 64'd0);
        chk("rst_tna", 64'(take_no_action), 64'd0);
        chk("rst_ir", 64'(ir_latched), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("prime_valid", 64'(cmd_valid), 64'd0);
            chk("prime_count", 64'(fifo_count), 64'd0);
        end

        // Action command: IR=2 and MSB=1, with latency checked edge by edge.
        toggle_uir(2'd2);
        tick(S + 3);
        chk("ir_latched", 64'(ir_latched), 64'd2);
        ir_cur    = 2'd2;
        cmd_ready = 1'b1;
        toggle_e1dr({1'b1, 5'd0, 32'hDEADBEEF}, 1'b1);
        tick(S);
        chk("lat_early", 64'(cmd_valid), 64'd0);
        tick(1);
        chk("lat_edge", 64'(cmd_valid), 64'd1);
        chk("head_ir", 64'(cmd_ir), 64'd2);
        chk("head_data", 64'(cmd_data[31:0]), 64'hDEADBEEF);
        tick(1);
        chk("ta_dir", 64'(take_action), 64'b0100);
        chk("tna_dir", 64'(take_no_action), 64'd0);
        tick(1);
        chk("ta_oneshot", 64'(take_action), 64'd0);

        // No-action command: IR=1 and MSB=0.
        toggle_uir(2'd1);
        tick(S + 3);
        ir_cur = 2'd1;
        toggle_e1dr(38'h00_1234_5678, 1'b1);
        tick(S + 2);
        chk("tna_dir2", 64'(take_no_action), 64'b0010);
        chk("ta_dir2", 64'(take_action), 64'd0);
        tick(1);
        chk("tna_oneshot", 64'(take_no_action), 64'd0);

        // Overflow: the 5th push into a 4-deep FIFO is dropped.
        cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            toggle_e1dr({k[0], 5'd0, 32'hA000_0000 + 32'(k)}, k < 4);
            tick(S + 3);
        end
        chk("ovf_count", 64'(fifo_count), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
`ifdef CPU_DEBUG_CMDQ_STATS_EN
        chk("drop_cnt", 64'(drop_count), 64'd1);
`endif
        cmd_ready = 1'b1;
        tick(6);
        cmd_ready = 1'b0;
        chk("drain_count", 64'(fifo_count), 64'd0);
        chk("drain_sb", 64'(exp_q.size()), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'd0);
`ifdef CPU_DEBUG_CMDQ_STATS_EN
        chk("drop_clr", 64'(drop_count), 64'd0);
`endif

        // Full FIFO with a push and a pop on the same edge.
        for (int k = 0; k < 4; k++) begin
            toggle_e1dr({~k[0], 5'd0, 32'hB000_0000 + 32'(k)}, 1'b1);
            tick(S + 3);
        end
        chk("full_count", 64'(fifo_count), 64'd4);
        toggle_e1dr({1'b1, 5'd0, 32'hC0DE_0001}, 1'b1);
        tick(S);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("pp_count", 64'(fifo_count), 64'd4);
        chk("pp_ovf", 64'(overflow), 64'd0);

        // A plain drop, then a drop in the same cycle as clr_ovf.
        toggle_e1dr(38'h00_0BAD_0001, 1'b0);
        tick(S + 3);
        chk("drop1_ovf", 64'(overflow), 64'd1);
`ifdef CPU_DEBUG_CMDQ_STATS_EN
        chk("drop1_cnt", 64'(drop_count), 64'd1);
`endif
        toggle_e1dr(38'h00_0BAD_0002, 1'b0);
        tick(S);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("clrdrop_ovf", 64'(overflow), 64'd1);
`ifdef CPU_DEBUG_CMDQ_STATS_EN
        chk("clrdrop_cnt", 64'(drop_count), 64'd1);
`endif
        chk("clrdrop_count", 64'(fifo_count), 64'd4);
        cmd_ready = 1'b1;
        tick(6);
        cmd_ready = 1'b0;
        chk("drain2_count", 64'(fifo_count), 64'd0);
        chk("drain2_sb", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation, with queued entries and one toggle in flight.
        toggle_e1dr(38'h20_0000_0011, 1'b1);
        tick(S + 3);
        toggle_e1dr(38'h00_0000_0022, 1'b1);
        tick(S + 3);
        toggle_e1dr(38'h20_0000_0033, 1'b0);
        tick(1);
        reset_n = 1'b0;
        exp_q.delete();
        tick(2);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        ir_cur  = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("post_rst_valid", 64'(cmd_valid), 64'd0);
        end
        chk("post_rst_ir", 64'(ir_latched), 64'd0);

        // After that reset, the block is re-primed and works again.
        cmd_ready = 1'b1;
        toggle_e1dr({1'b1, 5'd0, 32'h0000_5A5A}, 1'b1);
        tick(S + 1);
        chk("post_rst_lat", 64'(cmd_valid), 64'd1);
        tick(1);
        chk("post_rst_ta", 64'(take_action), 64'b0001);
        tick(3);
        chk("final_sb", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
